// File: rtl/punc_control.sv
// Control FSM for the PUnC LC3 datapath: fetch, decode, one to three execute
// cycles, plus a CC-update cycle after loads so CC comes from the ALU path.
//
// state  | meaning
// INIT   | clear PC after reset
// FETCH  | read mem[pc] into IR
// DECODE | bump PC, pick next state from opcode
// EXEC   | first execute cycle
// EXEC2  | second memory cycle of LDI/STI
// SETCC  | pass loaded DR through ALU to set CC
// HALT   | parked after TRAP until reset
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  output logic        mem_wr_en,
  output logic [2:0]  mem_r_addr_sel,
  output logic        state2_sti,
  output logic        str,
  output logic [2:0]  rf_wr_addr,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic        rf_wr_en,
  output logic [1:0]  rf_w_data_sel,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        cc_en,
  output logic        add_const,
  output logic        jmp_ret_jsrr,
  output logic [1:0]  alu_sel,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic [10:0] const_n,
  output logic [3:0]  sext_select,
  output logic [2:0]  state_dbg
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ALU_FN_ADD  = 2'd0;
  localparam logic [1:0] ALU_FN_AND  = 2'd1;
  localparam logic [1:0] ALU_FN_NOT  = 2'd2;
  localparam logic [1:0] ALU_FN_PASS = 2'd3;

  localparam logic [3:0] SEXT_IMM5  = 4'b1000;
  localparam logic [3:0] SEXT_OFF6  = 4'b0100;
  localparam logic [3:0] SEXT_OFF9  = 4'b0010;
  localparam logic [3:0] SEXT_OFF11 = 4'b0001;

  localparam logic [2:0] MRA_PC    = 3'd0;
  localparam logic [2:0] MRA_PCADD = 3'd1;
  localparam logic [2:0] MRA_IND   = 3'd2;
  localparam logic [2:0] MRA_ALU   = 3'd4;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_PC    = 2'd1;
  localparam logic [1:0] WD_MEM   = 2'd2;
  localparam logic [1:0] WD_PCADD = 2'd3;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_SETCC  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [3:0] opcode;
  logic [2:0] dr, sr1, sr2;
  logic       rf_wr_en_raw, mem_wr_en_raw;

  assign opcode    = ir[15:12];
  assign dr        = ir[11:9];
  assign sr1       = ir[8:6];
  assign sr2       = ir[2:0];
  assign const_n   = ir[10:0];
  assign state_dbg = state_q;

  // A reset cycle must not commit a register or memory write from an
  // interrupted instruction.
  assign rf_wr_en  = rf_wr_en_raw & ~rst;
  assign mem_wr_en = mem_wr_en_raw & ~rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_TRAP)
          state_d = S_HALT;
        else if (opcode == OP_RTI || opcode == OP_RSV)
          state_d = S_FETCH;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_LD, OP_LDR:  state_d = S_SETCC;
          OP_LDI, OP_STI: state_d = S_EXEC2;
          default:        state_d = S_FETCH;
        endcase
      end
      S_EXEC2:  state_d = (opcode == OP_LDI) ? S_SETCC : S_FETCH;
      S_SETCC:  state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_INIT;
    else
      state_q <= state_d;
  end

  always_comb begin
    mem_wr_en_raw  = 1'b0;
    mem_r_addr_sel = MRA_PC;
    state2_sti     = 1'b0;
    str            = 1'b0;
    rf_wr_addr     = 3'd0;
    rf_r_addr_0    = 3'd0;
    rf_r_addr_1    = 3'd0;
    rf_wr_en_raw   = 1'b0;
    rf_w_data_sel  = WD_ALU;
    ir_ld          = 1'b0;
    pc_ld          = 1'b0;
    pc_clr         = 1'b0;
    pc_up          = 1'b0;
    cc_en          = 1'b0;
    add_const      = 1'b0;
    jmp_ret_jsrr   = 1'b0;
    alu_sel        = ALU_FN_ADD;
    n              = 1'b0;
    z              = 1'b0;
    p              = 1'b0;
    sext_select    = 4'b0000;

    case (state_q)
      S_INIT: pc_clr = 1'b1;

      S_FETCH: begin
        mem_r_addr_sel = MRA_PC;
        ir_ld          = 1'b1;
      end

      S_DECODE: pc_up = 1'b1;

      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND: begin
            rf_r_addr_0   = sr1;
            rf_r_addr_1   = sr2;
            add_const     = ir[5];
            sext_select   = SEXT_IMM5;
            alu_sel       = (opcode == OP_ADD) ? ALU_FN_ADD : ALU_FN_AND;
            rf_wr_en_raw  = 1'b1;
            rf_wr_addr    = dr;
            rf_w_data_sel = WD_ALU;
            cc_en         = 1'b1;
          end
          OP_NOT: begin
            alu_sel       = ALU_FN_NOT;
            rf_r_addr_0   = sr1;
            rf_wr_en_raw  = 1'b1;
            rf_wr_addr    = dr;
            rf_w_data_sel = WD_ALU;
            cc_en         = 1'b1;
          end
          // Datapath evaluates the condition and loads PC on its own.
          OP_BR: begin
            n           = ir[11];
            z           = ir[10];
            p           = ir[9];
            sext_select = SEXT_OFF9;
          end
          OP_JMP: begin
            rf_r_addr_0  = sr1;
            alu_sel      = ALU_FN_PASS;
            jmp_ret_jsrr = 1'b1;
            pc_ld        = 1'b1;
          end
          // R7 captures the current (already incremented) PC in the same edge
          // that PC takes the target.
          OP_JSR: begin
            pc_ld         = 1'b1;
            rf_wr_en_raw  = 1'b1;
            rf_wr_addr    = 3'd7;
            rf_w_data_sel = WD_PC;
            if (ir[11]) begin
              sext_select = SEXT_OFF11;
            end else begin
              rf_r_addr_0  = sr1;
              alu_sel      = ALU_FN_PASS;
              jmp_ret_jsrr = 1'b1;
            end
          end
          OP_LD: begin
            sext_select    = SEXT_OFF9;
            mem_r_addr_sel = MRA_PCADD;
            rf_wr_en_raw   = 1'b1;
            rf_wr_addr     = dr;
            rf_w_data_sel  = WD_MEM;
          end
          OP_LDR: begin
            rf_r_addr_0    = sr1;
            add_const      = 1'b1;
            sext_select    = SEXT_OFF6;
            alu_sel        = ALU_FN_ADD;
            mem_r_addr_sel = MRA_ALU;
            rf_wr_en_raw   = 1'b1;
            rf_wr_addr     = dr;
            rf_w_data_sel  = WD_MEM;
          end
          OP_LDI, OP_STI: begin
            sext_select    = SEXT_OFF9;
            mem_r_addr_sel = MRA_PCADD;
          end
          OP_LEA: begin
            sext_select   = SEXT_OFF9;
            rf_wr_en_raw  = 1'b1;
            rf_wr_addr    = dr;
            rf_w_data_sel = WD_PCADD;
          end
          OP_ST: begin
            rf_r_addr_0   = dr;
            alu_sel       = ALU_FN_PASS;
            sext_select   = SEXT_OFF9;
            mem_wr_en_raw = 1'b1;
          end
          OP_STR: begin
            str           = 1'b1;
            rf_r_addr_0   = sr1;
            rf_r_addr_1   = dr;
            add_const     = 1'b1;
            sext_select   = SEXT_OFF6;
            alu_sel       = ALU_FN_ADD;
            mem_wr_en_raw = 1'b1;
          end
          default: ;
        endcase
      end

      S_EXEC2: begin
        if (opcode == OP_LDI) begin
          mem_r_addr_sel = MRA_IND;
          rf_wr_en_raw   = 1'b1;
          rf_wr_addr     = dr;
          rf_w_data_sel  = WD_MEM;
        end else if (opcode == OP_STI) begin
          state2_sti    = 1'b1;
          rf_r_addr_0   = dr;
          alu_sel       = ALU_FN_PASS;
          mem_wr_en_raw = 1'b1;
        end
      end

      S_SETCC: begin
        rf_r_addr_0 = dr;
        alu_sel     = ALU_FN_PASS;
        cc_en       = 1'b1;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_punc_control.sv
// Directed-vector bench for punc_control: per-cycle control word checks over
// a program of every opcode class, plus reset-mid-instruction and HALT runs.
module tb_punc_control;

  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3;
  localparam logic [2:0] S_E2 = 3'd4, S_C = 3'd5, S_H = 3'd6;
  localparam logic [1:0] A_ADD = 2'd0, A_AND = 2'd1, A_NOT = 2'd2, A_PASS = 2'd3;

  typedef struct packed {
    logic [2:0] st;
    logic       mwe;
    logic [2:0] mrs;
    logic       s2;
    logic       str;
    logic [2:0] wa;
    logic [2:0] ra0;
    logic [2:0] ra1;
    logic       we;
    logic [1:0] wsel;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_up;
    logic       cc_en;
    logic       add_const;
    logic       jrj;
    logic [1:0] alu;
    logic [2:0] nzp;
    logic [3:0] sext;
  } ctl_t;

  typedef struct packed {
    logic [15:0] ir;
    ctl_t        e;
  } vec_t;

  logic        clk, rst;
  logic [15:0] ir;
  logic        mem_wr_en, state2_sti, str, rf_wr_en, ir_ld, pc_ld, pc_clr, pc_up;
  logic        cc_en, add_const, jmp_ret_jsrr, n, z, p;
  logic [2:0]  mem_r_addr_sel, rf_wr_addr, rf_r_addr_0, rf_r_addr_1, state_dbg;
  logic [1:0]  rf_w_data_sel, alu_sel;
  logic [10:0] const_n;
  logic [3:0]  sext_select;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir),
    .mem_wr_en(mem_wr_en), .mem_r_addr_sel(mem_r_addr_sel), .state2_sti(state2_sti),
    .str(str), .rf_wr_addr(rf_wr_addr), .rf_r_addr_0(rf_r_addr_0),
    .rf_r_addr_1(rf_r_addr_1), .rf_wr_en(rf_wr_en), .rf_w_data_sel(rf_w_data_sel),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_up(pc_up), .cc_en(cc_en),
    .add_const(add_const), .jmp_ret_jsrr(jmp_ret_jsrr), .alu_sel(alu_sel),
    .n(n), .z(z), .p(p), .const_n(const_n), .sext_select(sext_select),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t c(input logic [2:0] st);
    c = '0;
    c.st = st;
  endfunction

  function automatic ctl_t cap();
    cap = '0;
    cap.st = state_dbg; cap.mwe = mem_wr_en; cap.mrs = mem_r_addr_sel;
    cap.s2 = state2_sti; cap.str = str; cap.wa = rf_wr_addr;
    cap.ra0 = rf_r_addr_0; cap.ra1 = rf_r_addr_1; cap.we = rf_wr_en;
    cap.wsel = rf_w_data_sel; cap.ir_ld = ir_ld; cap.pc_ld = pc_ld;
    cap.pc_clr = pc_clr; cap.pc_up = pc_up; cap.cc_en = cc_en;
    cap.add_const = add_const; cap.jrj = jmp_ret_jsrr; cap.alu = alu_sel;
    cap.nzp = {n, z, p}; cap.sext = sext_select;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] i, input ctl_t e);
    vec_t v;
    v.ir = i;
    v.e = e;
    vq.push_back(v);
  endtask

  // Entered just after a posedge; checks at the negedge, leaves just after the next posedge.
  task automatic step(input string name, input logic [15:0] i, input ctl_t e);
    ir = i;
    @(negedge clk);
    chk(name, 64'(cap()), 64'(e));
    chk({name, "_constn"}, 64'(const_n), 64'(i[10:0]));
    chk({name, "_pc1hot"}, 64'($countones({pc_clr, pc_up, pc_ld}) <= 1), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input logic [15:0] i, input logic [15:0] prev);
    ctl_t e;
    e = c(S_F); e.ir_ld = 1'b1; add(prev, e);
    e = c(S_D); e.pc_up = 1'b1; add(i, e);
  endtask

  initial begin
    ctl_t e;
    rst = 1'b1;
    ir  = 16'h0000;

    e = c(S_I); e.pc_clr = 1'b1; add(16'h0000, e);
    // ADD R1,R0,#5
    fd(16'h1225, 16'h0000);
    e = c(S_E); e.ra1 = 3'd5; e.add_const = 1'b1; e.sext = 4'b1000; e.alu = A_ADD;
    e.we = 1'b1; e.wa = 3'd1; e.cc_en = 1'b1; add(16'h1225, e);
    // AND R3,R4,R5
    fd(16'h5705, 16'h1225);
    e = c(S_E); e.ra0 = 3'd4; e.ra1 = 3'd5; e.sext = 4'b1000; e.alu = A_AND;
    e.we = 1'b1; e.wa = 3'd3; e.cc_en = 1'b1; add(16'h5705, e);
    // NOT R2,R6
    fd(16'h95BF, 16'h5705);
    e = c(S_E); e.ra0 = 3'd6; e.alu = A_NOT; e.we = 1'b1; e.wa = 3'd2; e.cc_en = 1'b1;
    add(16'h95BF, e);
    // BRz #-1; FETCH/DECODE hold BR-looking IRs but must not drive n/z/p
    fd(16'h05FF, 16'h0FFF);
    e = c(S_E); e.nzp = 3'b010; e.sext = 4'b0010; add(16'h05FF, e);
    // JSR #4
    fd(16'h4804, 16'h05FF);
    e = c(S_E); e.sext = 4'b0001; e.pc_ld = 1'b1; e.we = 1'b1; e.wa = 3'd7; e.wsel = 2'd1;
    add(16'h4804, e);
    // RET
    fd(16'hC1C0, 16'h4804);
    e = c(S_E); e.ra0 = 3'd7; e.alu = A_PASS; e.jrj = 1'b1; e.pc_ld = 1'b1; add(16'hC1C0, e);
    // JSRR R3
    fd(16'h40C0, 16'hC1C0);
    e = c(S_E); e.ra0 = 3'd3; e.alu = A_PASS; e.jrj = 1'b1; e.pc_ld = 1'b1;
    e.we = 1'b1; e.wa = 3'd7; e.wsel = 2'd1; add(16'h40C0, e);
    // LD R4,#3
    fd(16'h2803, 16'h40C0);
    e = c(S_E); e.sext = 4'b0010; e.mrs = 3'd1; e.we = 1'b1; e.wa = 3'd4; e.wsel = 2'd2;
    add(16'h2803, e);
    e = c(S_C); e.ra0 = 3'd4; e.alu = A_PASS; e.cc_en = 1'b1; add(16'h2803, e);
    // LDR R5,R1,#-2
    fd(16'h6A7E, 16'h2803);
    e = c(S_E); e.ra0 = 3'd1; e.add_const = 1'b1; e.sext = 4'b0100; e.alu = A_ADD;
    e.mrs = 3'd4; e.we = 1'b1; e.wa = 3'd5; e.wsel = 2'd2; add(16'h6A7E, e);
    e = c(S_C); e.ra0 = 3'd5; e.alu = A_PASS; e.cc_en = 1'b1; add(16'h6A7E, e);
    // LDI R2,#1
    fd(16'hA401, 16'h6A7E);
    e = c(S_E); e.sext = 4'b0010; e.mrs = 3'd1; add(16'hA401, e);
    e = c(S_E2); e.mrs = 3'd2; e.we = 1'b1; e.wa = 3'd2; e.wsel = 2'd2; add(16'hA401, e);
    e = c(S_C); e.ra0 = 3'd2; e.alu = A_PASS; e.cc_en = 1'b1; add(16'hA401, e);
    // LEA R6,#7
    fd(16'hEC07, 16'hA401);
    e = c(S_E); e.sext = 4'b0010; e.we = 1'b1; e.wa = 3'd6; e.wsel = 2'd3; add(16'hEC07, e);
    // ST R1,#2
    fd(16'h3202, 16'hEC07);
    e = c(S_E); e.ra0 = 3'd1; e.alu = A_PASS; e.sext = 4'b0010; e.mwe = 1'b1;
    add(16'h3202, e);
    // STR R2,R3,#1
    fd(16'h74C1, 16'h3202);
    e = c(S_E); e.str = 1'b1; e.ra0 = 3'd3; e.ra1 = 3'd2; e.add_const = 1'b1;
    e.sext = 4'b0100; e.alu = A_ADD; e.mwe = 1'b1; add(16'h74C1, e);
    // STI R3,#2: store strobe only in EXEC2
    fd(16'hB602, 16'h74C1);
    e = c(S_E); e.sext = 4'b0010; e.mrs = 3'd1; add(16'hB602, e);
    e = c(S_E2); e.s2 = 1'b1; e.ra0 = 3'd3; e.alu = A_PASS; e.mwe = 1'b1; add(16'hB602, e);
    // two no-op opcodes, 2 cycles each
    fd(16'h8000, 16'hB602);
    fd(16'hD000, 16'h8000);
    e = c(S_F); e.ir_ld = 1'b1; add(16'hD000, e);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++)
      step($sformatf("vec%0d", i), vq[i].ir, vq[i].e);

    // Reset in EXEC2 of LDI: write suppressed, next state INIT.
    e = c(S_D); e.pc_up = 1'b1; step("ldi_rst_dec", 16'hA401, e);
    e = c(S_E); e.sext = 4'b0010; e.mrs = 3'd1; step("ldi_rst_exec", 16'hA401, e);
    rst = 1'b1;
    @(negedge clk);
    chk("ldi_rst_state", 64'(state_dbg), 64'(S_E2));
    chk("ldi_rst_no_wr", 64'(rf_wr_en), 64'd0);
    chk("ldi_rst_no_mwr", 64'(mem_wr_en), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    e = c(S_I); e.pc_clr = 1'b1; step("ldi_rst_init", 16'hA401, e);

    // TRAP: park in HALT with everything low
    e = c(S_F); e.ir_ld = 1'b1; step("trap_fetch", 16'hA401, e);
    e = c(S_D); e.pc_up = 1'b1; step("trap_dec", 16'hF025, e);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("halt%0d", k), 64'(cap()), 64'(c(S_H)));
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    e = c(S_I); e.pc_clr = 1'b1; step("halt_rst_init", 16'hF025, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
